// File: rtl/muxs_pipe_if.sv
// Decode, operand and writeback signals of muxs_pipe.
// The core side (master) drives decode fields and memory data; muxs_pipe (slave) returns PC and results.
interface muxs_pipe_if #(
   parameter int unsigned DataSize = 32,
   parameter int unsigned PcWidth  = 10
);
   logic                stall;
   logic                flush;
   logic                in_valid;
   logic [2:0]          pc_select;
   logic [1:0]          sub_op_sv;
   logic [4:0]          imm_5bit;
   logic [13:0]         imm_14bit;
   logic [14:0]         imm_15bit;
   logic [19:0]         imm_20bit;
   logic [23:0]         imm_24bit;
   logic [1:0]          imm_extend_select;
   logic [2:0]          alu_src2_select;
   logic [1:0]          write_reg_select;
   logic [DataSize-1:0] reg_rb_data;
   logic [DataSize-1:0] reg_rt_data;
   logic [DataSize-1:0] alu_output;
   logic [DataSize-1:0] mem_read_data;
   logic                mem_valid;
   logic [PcWidth-1:0]  current_pc;
   logic [PcWidth-1:0]  next_pc;
   logic [DataSize-1:0] output_imm_reg_mux;
   logic                out_valid;
   logic [DataSize-1:0] write_reg_data;
   logic                wb_valid;
   logic                mem_wait;

   modport master (
      output stall, flush, in_valid, pc_select, sub_op_sv, imm_5bit, imm_14bit, imm_15bit,
             imm_20bit, imm_24bit, imm_extend_select, alu_src2_select, write_reg_select,
             reg_rb_data, reg_rt_data, alu_output, mem_read_data, mem_valid,
      input  current_pc, next_pc, output_imm_reg_mux, out_valid, write_reg_data, wb_valid,
             mem_wait
   );

   modport slave (
      input  stall, flush, in_valid, pc_select, sub_op_sv, imm_5bit, imm_14bit, imm_15bit,
             imm_20bit, imm_24bit, imm_extend_select, alu_src2_select, write_reg_select,
             reg_rb_data, reg_rt_data, alu_output, mem_read_data, mem_valid,
      output current_pc, next_pc, output_imm_reg_mux, out_valid, write_reg_data, wb_valid,
             mem_wait
   );
endinterface

// File: rtl/muxs_pipe.sv
// Registered datapath select unit: PC register with next-PC selection, registered ALU src2
// operand with stall/flush, and registered writeback data with a load-wait FSM.
module muxs_pipe #(
   parameter int unsigned        DataSize = 32,
   parameter int unsigned        PcWidth  = 10,
   parameter logic [PcWidth-1:0] PcReset  = '0
) (
   input logic        clk,
   input logic        rst,
   muxs_pipe_if.slave bus
);
   typedef enum logic [0:0] {StIdle, StWaitMem} wb_state_e;

   logic [PcWidth-1:0]  pc_q, next_pc_c;
   logic [DataSize-1:0] imm_ext, src2, op_q;
   logic                op_valid_q, taken_q, accept;
   logic [1:0]          wb_sel_q;
   logic [DataSize-1:0] wb_data_q, wb_data_d;
   logic                wb_valid_q, wb_valid_d, mem_wait_q, mem_wait_d;
   wb_state_e           state_q, state_d;

   // Offsets are sign-extended (or truncated) straight to PcWidth so wrap-around is implicit.
   always_comb begin
      next_pc_c = pc_q;
      case (bus.pc_select)
         3'b000:  next_pc_c = pc_q + PcWidth'(3'd4);
         3'b001:  next_pc_c = pc_q + PcWidth'($signed({bus.imm_14bit, 1'b0}));
         3'b010:  next_pc_c = pc_q + PcWidth'($signed({bus.imm_24bit, 1'b0}));
         3'b011:  next_pc_c = bus.reg_rb_data[PcWidth-1:0];
         default: next_pc_c = pc_q;
      endcase
   end

   always_comb begin
      imm_ext = '0;
      case (bus.imm_extend_select)
         2'b00:   imm_ext = DataSize'(bus.imm_5bit);
         2'b01:   imm_ext = DataSize'($signed(bus.imm_15bit));
         2'b10:   imm_ext = DataSize'(bus.imm_15bit);
         default: imm_ext = DataSize'($signed(bus.imm_20bit));
      endcase
   end

   always_comb begin
      src2 = '0;
      case (bus.alu_src2_select)
         3'b000:  src2 = bus.reg_rb_data;
         3'b001:  src2 = imm_ext;
         3'b010:  src2 = DataSize'({bus.imm_15bit, 2'b00});
         3'b011:  src2 = bus.reg_rb_data << bus.sub_op_sv;
         3'b100:  src2 = bus.reg_rt_data;
         default: src2 = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= PcReset;
      end else if (bus.in_valid && !bus.stall) begin
         pc_q <= next_pc_c;
      end
   end

   // taken_q stops an operand held by stall from being written back more than once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q       <= '0;
         op_valid_q <= 1'b0;
         wb_sel_q   <= 2'b11;
         taken_q    <= 1'b0;
      end else if (!bus.stall) begin
         op_q       <= src2;
         op_valid_q <= bus.in_valid && !bus.flush;
         wb_sel_q   <= bus.write_reg_select;
         taken_q    <= 1'b0;
      end else if (accept) begin
         taken_q    <= 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      wb_data_d  = wb_data_q;
      wb_valid_d = 1'b0;
      accept     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (op_valid_q && !taken_q) begin
               accept = 1'b1;
               case (wb_sel_q)
                  2'b00: begin
                     wb_data_d  = bus.alu_output;
                     wb_valid_d = 1'b1;
                  end
                  2'b01: begin
                     wb_data_d  = op_q;
                     wb_valid_d = 1'b1;
                  end
                  2'b10: begin
                     if (bus.mem_valid) begin
                        wb_data_d  = bus.mem_read_data;
                        wb_valid_d = 1'b1;
                     end else begin
                        state_d = StWaitMem;
                     end
                  end
                  default: ;
               endcase
            end
         end
         StWaitMem: begin
            if (bus.mem_valid) begin
               wb_data_d  = bus.mem_read_data;
               wb_valid_d = 1'b1;
               state_d    = StIdle;
            end
         end
      endcase
      mem_wait_d = (state_d == StWaitMem);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         wb_data_q  <= '0;
         wb_valid_q <= 1'b0;
         mem_wait_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wb_data_q  <= wb_data_d;
         wb_valid_q <= wb_valid_d;
         mem_wait_q <= mem_wait_d;
      end
   end

   assign bus.current_pc         = pc_q;
   assign bus.next_pc            = next_pc_c;
   assign bus.output_imm_reg_mux = op_q;
   assign bus.out_valid          = op_valid_q;
   assign bus.write_reg_data     = wb_data_q;
   assign bus.wb_valid           = wb_valid_q;
   assign bus.mem_wait           = mem_wait_q;
endmodule
